// File: rtl/pwm_multi_shadow_if.sv
// rtl/pwm_multi_shadow_if.sv - register-file side bundle for the N-channel PWM
interface pwm_multi_shadow_if #(
    parameter int NCH   = 8,
    parameter int WIDTH = 32
);
    logic [NCH-1:0]       en_i;
    logic [NCH-1:0]       pol_i;
    logic [NCH-1:0]       load_i;
    logic [NCH*WIDTH-1:0] period_i;
    logic [NCH*WIDTH-1:0] duty_i;
    logic [NCH-1:0]       pwm_o;
    logic [NCH-1:0]       wrap_o;
    logic [NCH-1:0]       pend_o;

    // Register file: drives configuration, observes outputs
    modport master (
        output en_i, pol_i, load_i, period_i, duty_i,
        input  pwm_o, wrap_o, pend_o
    );

    // PWM block: consumes configuration, produces outputs
    modport slave (
        input  en_i, pol_i, load_i, period_i, duty_i,
        output pwm_o, wrap_o, pend_o
    );
endinterface

// File: rtl/pwm_multi_shadow.sv
// rtl/pwm_multi_shadow.sv - N-channel PWM with shadowed period/duty applied at period boundaries
module pwm_multi_shadow #(
    parameter int NCH   = 8,
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    pwm_multi_shadow_if.slave  bus
);

    logic [NCH-1:0] pwm_vec;
    logic [NCH-1:0] wrap_vec;
    logic [NCH-1:0] pend_vec;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WIDTH-1:0] per_in;
        logic [WIDTH-1:0] duty_in;
        logic             en;
        logic             pol;
        logic             load;

        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] per_act_q, per_act_d;
        logic [WIDTH-1:0] duty_act_q, duty_act_d;
        logic [WIDTH-1:0] per_sh_q, per_sh_d;
        logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
        logic             pend_q, pend_d;
        logic             pwm_q, pwm_d;
        logic             wrap_q, wrap_d;

        assign per_in  = bus.period_i[c*WIDTH +: WIDTH];
        assign duty_in = bus.duty_i[c*WIDTH +: WIDTH];
        assign en      = bus.en_i[c];
        assign pol     = bus.pol_i[c];
        assign load    = bus.load_i[c];

        // Next-state: shadow capture, counter advance, boundary apply and output compare
        always_comb begin
            cnt_d      = cnt_q;
            per_act_d  = per_act_q;
            duty_act_d = duty_act_q;
            per_sh_d   = per_sh_q;
            duty_sh_d  = duty_sh_q;
            pend_d     = pend_q;
            pwm_d      = pwm_q;
            wrap_d     = wrap_q;

            // A new load always lands in the shadow and replaces anything not yet applied
            if (load) begin
                per_sh_d  = per_in;
                duty_sh_d = duty_in;
                pend_d    = 1'b1;
            end

            if (!en) begin
                // Idle: hold counter at zero, drive the inactive level, apply pending shadow.
                // A load in this same cycle stays pending because it only reaches the shadow now.
                cnt_d  = '0;
                pwm_d  = pol;
                wrap_d = 1'b0;
                if (pend_q) begin
                    per_act_d  = per_sh_q;
                    duty_act_d = duty_sh_q;
                    pend_d     = load;
                end
            end else begin
                // Compare uses the pre-edge counter, so the output trails it by one cycle
                pwm_d = (cnt_q < duty_act_q) ^ pol;
                if (cnt_q == per_act_q) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                    if (load) begin
                        // Load on the boundary bypasses the shadow and takes effect immediately
                        per_act_d  = per_in;
                        duty_act_d = duty_in;
                        pend_d     = 1'b0;
                    end else if (pend_q) begin
                        per_act_d  = per_sh_q;
                        duty_act_d = duty_sh_q;
                        pend_d     = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_q + WIDTH'(1);
                    wrap_d = 1'b0;
                end
            end
        end

        // Channel state registers, cleared asynchronously
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q      <= '0;
                per_act_q  <= '0;
                duty_act_q <= '0;
                per_sh_q   <= '0;
                duty_sh_q  <= '0;
                pend_q     <= 1'b0;
                pwm_q      <= 1'b0;
                wrap_q     <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                per_act_q  <= per_act_d;
                duty_act_q <= duty_act_d;
                per_sh_q   <= per_sh_d;
                duty_sh_q  <= duty_sh_d;
                pend_q     <= pend_d;
                pwm_q      <= pwm_d;
                wrap_q     <= wrap_d;
            end
        end

        assign pwm_vec[c]  = pwm_q;
        assign wrap_vec[c] = wrap_q;
        assign pend_vec[c] = pend_q;
    end

    assign bus.pwm_o  = pwm_vec;
    assign bus.wrap_o = wrap_vec;
    assign bus.pend_o = pend_vec;

endmodule
